opti_sos_sched: RTL and testbench

Control FSM for the time-multiplexed 4-section biquad IIR datapath. It accepts one input sample through a valid/ready handshake. It then steps the coefficient-select index through every section and issues five MAC micro-ops per section (b0·x, b1·x1, b2·x2, a1·y1, a2·y2). After each section it pulses a writeback strobe for the delay-line/state registers, and it presents the final result through an output valid/ready handshake. This block holds no arithmetic; it only sequences the coefficient ROM, the shared MAC and the section state memory.

---
 rtl/opti_sos_sched.sv | 121 ++++++++++++
 tb/tb_opti_sos_sched.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/opti_sos_sched.sv
// Sequencer for a time-multiplexed biquad cascade.
// Drives the coefficient ROM, the shared MAC and the section state memory.
module opti_sos_sched #(
    parameter int NSEC  = 4,
    parameter int SEC_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic             state_clr,
    output logic [SEC_W-1:0] sos_idx,
    output logic [2:0]       mac_sel,
    output logic             mac_en,
    output logic             mac_clr,
    output logic             state_we,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_WB,
        S_DONE
    } state_t;

    localparam logic [SEC_W-1:0] LAST_SEC = SEC_W'(NSEC - 1);
    localparam logic [2:0]       LAST_OP  = 3'd4;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SEC_W-1:0] r_sec;
    logic [SEC_W-1:0] w_sec_nxt;
    logic [2:0]       r_step;
    logic [2:0]       w_step_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sec   <= '0;
            r_step  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sec   <= w_sec_nxt;
            r_step  <= w_step_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sec_nxt   = r_sec;
        w_step_nxt  = r_step;
        unique case (r_state)
            S_IDLE: begin
                // flush wins over a simultaneous sample
                if (!flush && in_valid) begin
                    w_state_nxt = S_MAC;
                    w_sec_nxt   = '0;
                    w_step_nxt  = '0;
                end
            end
            S_MAC: begin
                if (r_step == LAST_OP) begin
                    w_state_nxt = S_WB;
                    w_step_nxt  = '0;
                end else begin
                    w_step_nxt = r_step + 3'd1;
                end
            end
            S_WB: begin
                if (r_sec == LAST_SEC) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_MAC;
                    w_sec_nxt   = r_sec + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        state_clr = 1'b0;
        sos_idx   = r_sec;
        mac_sel   = r_step;
        mac_en    = 1'b0;
        mac_clr   = 1'b0;
        state_we  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                busy      = 1'b0;
                in_ready  = !flush;
                state_clr = flush;
            end
            S_MAC: begin
                mac_en  = 1'b1;
                mac_clr = (r_step == 3'd0);
            end
            S_WB: begin
                state_we = 1'b1;
            end
            S_DONE: begin
                out_valid = 1'b1;
                sos_idx   = LAST_SEC;
            end
            default: busy = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_opti_sos_sched.sv
// Directed vector bench for the biquad sequencer (NSEC=4 and NSEC=1).
// Expected values come from the per-sample cycle timing of the schedule.
module tb_opti_sos_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst4, iv4, fl4, or4;
    logic       ir4, sc4, me4, mc4, we4, ov4, bz4;
    logic [1:0] sos4;
    logic [2:0] sel4;

    logic       rst1, iv1, fl1, or1;
    logic       ir1, sc1, me1, mc1, we1, ov1, bz1;
    logic [0:0] sos1;
    logic [2:0] sel1;

    opti_sos_sched #(.NSEC(4), .SEC_W(2)) dut4 (
        .clk(clk), .rst_n(rst4), .in_valid(iv4), .in_ready(ir4),
        .flush(fl4), .state_clr(sc4), .sos_idx(sos4), .mac_sel(sel4),
        .mac_en(me4), .mac_clr(mc4), .state_we(we4), .out_valid(ov4),
        .out_ready(or4), .busy(bz4)
    );

    opti_sos_sched #(.NSEC(1), .SEC_W(1)) dut1 (
        .clk(clk), .rst_n(rst1), .in_valid(iv1), .in_ready(ir1),
        .flush(fl1), .state_clr(sc1), .sos_idx(sos1), .mac_sel(sel1),
        .mac_en(me1), .mac_clr(mc1), .state_we(we1), .out_valid(ov1),
        .out_ready(or1), .busy(bz1)
    );

    typedef struct {
        bit    u1;
        logic  rst, iv, fl, orr;
        logic  ir, sc;
        int    sos, sel;
        logic  me, mc, we, ov, bz;
        bit    csos;
        string nm;
    } vec_t;

    vec_t vq[$];
    int   nerr = 0;
    int   nchk = 0;

    task automatic chk(input string nm, input logic [7:0] a, input logic [7:0] e);
        nchk++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, a, e, $time);
        end
    endtask

    task automatic add(input bit u1, input logic rst, iv, fl, orr,
                       input logic ir, sc, input int sos, sel,
                       input logic me, mc, we, ov, bz,
                       input bit csos, input string nm);
        vec_t v;
        v.u1 = u1; v.rst = rst; v.iv = iv; v.fl = fl; v.orr = orr;
        v.ir = ir; v.sc = sc; v.sos = sos; v.sel = sel;
        v.me = me; v.mc = mc; v.we = we; v.ov = ov; v.bz = bz;
        v.csos = csos; v.nm = nm;
        vq.push_back(v);
    endtask

    // cycles T+1 .. of one sample; stall = extra DONE cycles with out_ready=0
    task automatic add_sample(input bit u1, input int n, input int stall,
                              input int upto, input logic iv);
        for (int d = 1; d <= 6 * n; d++) begin
            int k, r;
            if (d > upto) return;
            k = (d - 1) / 6;
            r = (d - 1) % 6;
            if (r < 5)
                add(u1, 1, iv, 0, 1, 0, 0, k, r, 1, (r == 0), 0, 0, 1, 1,
                    $sformatf("mac_T+%0d", d));
            else
                add(u1, 1, iv, 0, 1, 0, 0, k, 0, 0, 0, 1, 0, 1, 1,
                    $sformatf("wb_T+%0d", d));
        end
        if (upto <= 6 * n) return;
        for (int s = 0; s <= stall; s++)
            add(u1, 1, iv, 0, (s == stall), 0, 0, n - 1, 0, 0, 0, 0, 1, 1, 1,
                $sformatf("done_T+%0d", 6 * n + 1 + s));
    endtask

    logic       a_ir, a_sc, a_me, a_mc, a_we, a_ov, a_bz;
    logic [7:0] a_sos, a_sel;

    task automatic idle_inputs();
        rst4 = 1; iv4 = 0; fl4 = 0; or4 = 1;
        rst1 = 1; iv1 = 0; fl1 = 0; or1 = 1;
    endtask

    int acc, hs, wes, viol, badsel, cyc;

    initial begin
        rst4 = 0; iv4 = 0; fl4 = 0; or4 = 1;
        rst1 = 0; iv1 = 0; fl1 = 0; or1 = 1;

        // reset state of both instances
        add(0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, "rst_idle4");
        add(1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, "rst_idle1");
        // sample 1, in_valid held
        add(0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, "acc1");
        add_sample(0, 4, 0, 99, 1);
        // T+26: back in IDLE, accepts sample 2
        add(0, 1, 1, 0, 1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, "acc2");
        add_sample(0, 4, 10, 99, 0);
        add(0, 1, 0, 0, 1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, "idle_after_stall");
        // flush beats in_valid
        add(0, 1, 1, 1, 1, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, "flush");
        add(0, 1, 1, 0, 1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, "acc3");
        // reset mid-sample at T+10 (section 1, step 3)
        add_sample(0, 4, 0, 9, 0);
        add(0, 0, 0, 0, 1, 0, 0, 1, 3, 1, 0, 0, 0, 1, 1, "rst_cycle");
        for (int i = 0; i < 3; i++)
            add(0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1,
                $sformatf("post_rst%0d", i));
        // NSEC=1 instance
        add(1, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, "n1_acc");
        add_sample(1, 1, 0, 99, 0);
        add(1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, "n1_idle");

        repeat (2) @(posedge clk);
        #1 idle_inputs();

        foreach (vq[i]) begin
            @(posedge clk);
            #1;
            idle_inputs();
            if (vq[i].u1) begin
                rst1 = vq[i].rst; iv1 = vq[i].iv; fl1 = vq[i].fl; or1 = vq[i].orr;
            end else begin
                rst4 = vq[i].rst; iv4 = vq[i].iv; fl4 = vq[i].fl; or4 = vq[i].orr;
            end
            #3;
            if (vq[i].u1) begin
                a_ir = ir1; a_sc = sc1; a_me = me1; a_mc = mc1; a_we = we1;
                a_ov = ov1; a_bz = bz1; a_sos = {7'b0, sos1}; a_sel = {5'b0, sel1};
            end else begin
                a_ir = ir4; a_sc = sc4; a_me = me4; a_mc = mc4; a_we = we4;
                a_ov = ov4; a_bz = bz4; a_sos = {6'b0, sos4}; a_sel = {5'b0, sel4};
            end
            chk({vq[i].nm, ".in_ready"}, {7'b0, a_ir}, {7'b0, vq[i].ir});
            chk({vq[i].nm, ".state_clr"}, {7'b0, a_sc}, {7'b0, vq[i].sc});
            chk({vq[i].nm, ".mac_sel"}, a_sel, 8'(vq[i].sel));
            chk({vq[i].nm, ".mac_en"}, {7'b0, a_me}, {7'b0, vq[i].me});
            chk({vq[i].nm, ".mac_clr"}, {7'b0, a_mc}, {7'b0, vq[i].mc});
            chk({vq[i].nm, ".state_we"}, {7'b0, a_we}, {7'b0, vq[i].we});
            chk({vq[i].nm, ".out_valid"}, {7'b0, a_ov}, {7'b0, vq[i].ov});
            chk({vq[i].nm, ".busy"}, {7'b0, a_bz}, {7'b0, vq[i].bz});
            if (vq[i].csos)
                chk({vq[i].nm, ".sos_idx"}, a_sos, 8'(vq[i].sos));
        end

        // 100 back-to-back samples with random output stalls
        acc = 0; hs = 0; wes = 0; viol = 0; badsel = 0; cyc = 0;
        while ((hs < 100 || bz4) && cyc < 8000) begin
            @(posedge clk);
            #1;
            idle_inputs();
            iv4 = (acc < 100);
            or4 = 1'($urandom_range(0, 1));
            #3;
            cyc++;
            if (iv4 && ir4) acc++;
            if (ov4 && or4) hs++;
            if (we4) wes++;
            if (me4 && we4) viol++;
            if (mc4 && !me4) viol++;
            if (sel4 > 3'd4) badsel++;
            if (ir4 && bz4) viol++;
        end
        chk("bulk.accepts", 8'(acc), 8'd100);
        chk("bulk.handshakes", 8'(hs), 8'd100);
        chk("bulk.wb_lo", 8'(wes), 8'(400));
        chk("bulk.wb_hi", 8'(wes >> 8), 8'(400 >> 8));
        chk("bulk.overlap", 8'(viol), 8'd0);
        chk("bulk.mac_sel", 8'(badsel), 8'd0);
        chk("bulk.idle", {7'b0, ir4}, 8'd1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
